// File: rtl/d_ff_pkg.sv
// Shared defaults and legality helpers for the d_ff register pipeline.
package d_ff_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH = 3;
  localparam int unsigned DFF_DEFAULT_RESET = 0;
  localparam int unsigned DFF_MAX_STAGES    = 16;
  localparam int unsigned DFF_MAX_WIDTH     = 64;

  // True when a data width is supported by the pipeline.
  function automatic bit dff_width_ok(input int unsigned w);
    return (w >= 1) && (w <= DFF_MAX_WIDTH);
  endfunction

  // True when a stage count is supported by the pipeline.
  function automatic bit dff_stages_ok(input int unsigned n);
    return (n >= 1) && (n <= DFF_MAX_STAGES);
  endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register with asynchronous active-low reset to RESET_VALUE.
module d_ff_stage
  import d_ff_pkg::*;
#(
  parameter int unsigned      WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on each rising edge; reset forces RESET_VALUE without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_ff.sv
// Cascade of STAGES d_ff_stage registers from d to q; q is the last flop output.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int unsigned WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [63:0] RESET_VALUE = 64'(DFF_DEFAULT_RESET),
  parameter int unsigned STAGES      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Wider reset values are truncated to the data width.
  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  if (!dff_width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "d_ff: WIDTH=%0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
  end

  if (!dff_stages_ok(STAGES)) begin : g_bad_stages
    $fatal(1, "d_ff: STAGES=%0d outside 1..%0d", STAGES, DFF_MAX_STAGES);
  end

  // chain[0] is the input; chain[k] is the output of stage k.
  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = d;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (chain[i]),
      .q     (chain[i+1])
    );
  end

  assign q = chain[STAGES];

endmodule

// File: tb/tb_d_ff.sv
// Scoreboard bench for d_ff: a 1-stage and a 3-stage instance share clk, rst_n and d.
module tb_d_ff;
  import d_ff_pkg::*;

  localparam int unsigned W   = 3;
  localparam logic [W-1:0] RV1 = 3'd0;
  localparam logic [W-1:0] RV3 = 3'd2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] d     = '0;
  logic [W-1:0] q1;
  logic [W-1:0] q3;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference history: newest sample at index 0, reset clears everything in flight.
  logic [W-1:0] hist1 [$];
  logic [W-1:0] hist3 [$];
  logic [W-1:0] exp1  [$];
  logic [W-1:0] exp3  [$];

  always #5 clk = ~clk;

  d_ff #(
    .WIDTH       (W),
    .RESET_VALUE (64'd0),
    .STAGES      (1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (q1)
  );

  d_ff #(
    .WIDTH       (W),
    .RESET_VALUE (64'd2),
    .STAGES      (3)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (q3)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: q is the sample taken N edges ago if N clean edges have passed, else the reset value.
  always @(posedge clk) begin
    if (!rst_n) begin
      hist1.delete();
      hist3.delete();
      exp1.push_back(RV1);
      exp3.push_back(RV3);
    end else begin
      hist1.push_front(d);
      hist3.push_front(d);
      if (hist1.size() > 1) void'(hist1.pop_back());
      if (hist3.size() > 3) void'(hist3.pop_back());
      exp1.push_back(hist1.size() >= 1 ? hist1[0] : RV1);
      exp3.push_back(hist3.size() >= 3 ? hist3[2] : RV3);
    end
  end

  // Reset discards every sample the model was holding.
  always @(negedge rst_n) begin
    hist1.delete();
    hist3.delete();
  end

  // Monitor: q is stable mid-cycle, so compare against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp1.size() > 0) check("q1_pipe", q1, exp1.pop_front());
    if (exp3.size() > 0) check("q3_pipe", q3, exp3.pop_front());
  end

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    d = v;
  endtask

  // Drop reset while clk is low and confirm both outputs clear before any edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_q1"}, q1, RV1);
    check({name, "_q3"}, q3, RV3);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] vals [4];

    // Held in reset: d changes every 10 units, q must not move.
    vals = '{3'd4, 3'd2, 3'd3, 3'd6};
    foreach (vals[i]) drive(vals[i]);

    // Release in the high phase straight after an edge: that edge saw reset, the next captures 5.
    drive(3'd5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("release_edge_q1", q1, RV1);
    drive(3'd5);

    // Plain pipeline traffic.
    foreach (vals[i]) drive(vals[i]);
    @(posedge clk);
    #1 check("last_value_q1", q1, 3'd6);

    // Asynchronous reset mid-cycle with q1 holding 6.
    async_reset("async_mid");

    // d toggles between edges; only the value present at each edge may reach q.
    for (int unsigned k = 0; k < 3; k++) begin
      drive(3'd1);
      @(posedge clk);
      #2 d = 3'd7;
      #1 check("no_transparency_q1", q1, 3'd1);
      #4 d = 3'd1;
    end

    // Fresh reset, then 1,2,3,4 through the 3-stage pipe; reset again mid-stream to flush.
    async_reset("pre_stream");
    vals = '{3'd1, 3'd2, 3'd3, 3'd4};
    foreach (vals[i]) drive(vals[i]);
    drive(3'd5);
    drive(3'd6);
    async_reset("flush");
    vals = '{3'd7, 3'd3, 3'd1, 3'd0};
    foreach (vals[i]) drive(vals[i]);

    // Random traffic with occasional reset pulses.
    for (int unsigned n = 0; n < 300; n++) begin
      drive(W'($urandom));
      if ($urandom_range(15) == 0) begin
        #3 rst_n = 1'b0;
        #1;
        check("rand_async_q1", q1, RV1);
        check("rand_async_q3", q3, RV3);
        repeat ($urandom_range(2, 1)) @(negedge clk);
        #3 rst_n = 1'b1;
      end
    end

    // Let the monitor drain the last expectations.
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (exp1.size() != 0 || exp3.size() != 0) begin
      bad++;
      $display("FAIL drain: pending q1=%0d q3=%0d expected 0", exp1.size(), exp3.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
